// File: rtl/coord_dropper_pkg.sv
// Shared definitions for the coordinate dropper: word width, token encodings
// and small token classification helpers.
package coord_dropper_pkg;

    localparam int unsigned DATA_WIDTH = 17;
    localparam logic [16:0] STOP_BASE  = 17'h10000;
    localparam logic [16:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {
        ST_START,
        ST_INNER,
        ST_DONE_WAIT_INNER,
        ST_DONE_WAIT_OUTER
    } state_e;

    function automatic logic is_stop(input logic [16:0] w);
        return w[16] && (w[9:8] == 2'b00);
    endfunction

    function automatic logic is_done(input logic [16:0] w);
        return w[16] && (w[9:8] == 2'b01);
    endfunction

    function automatic logic [7:0] stop_level(input logic [16:0] w);
        return w[7:0];
    endfunction

endpackage

// File: rtl/coord_dropper_stream_fifo.sv
// Small circular valid/ready FIFO; push is only issued by the owner when not full.
module stream_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (cnt_q == CNT_W'(DEPTH));
    assign out_valid_o = (cnt_q != '0);
    assign out_data_o  = mem_q[rd_q];
    assign do_pop      = en_i && out_valid_o && out_ready_i;
    assign do_push     = en_i && push_i && !full_o;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = next_ptr(wr_q);
        if (do_pop)  rd_d = next_ptr(rd_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end

endmodule

// File: rtl/coord_dropper.sv
// Drops outer coordinates whose inner fiber holds no coordinate; the inner
// stream is forwarded untouched. Pass-through copies both lanes when cmrg_mode=0.
module coord_dropper #(
    parameter int unsigned DATA_WIDTH = coord_dropper_pkg::DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,
    input  logic                  cmrg_enable,
    input  logic                  cmrg_mode,
    input  logic [15:0]           cmrg_stop_lvl,
    input  logic [DATA_WIDTH-1:0] cmrg_coord_in_0,
    input  logic                  cmrg_coord_in_0_valid,
    output logic                  cmrg_coord_in_0_ready,
    input  logic [DATA_WIDTH-1:0] cmrg_coord_in_1,
    input  logic                  cmrg_coord_in_1_valid,
    output logic                  cmrg_coord_in_1_ready,
    output logic [DATA_WIDTH-1:0] cmrg_coord_out_0,
    output logic                  cmrg_coord_out_0_valid,
    input  logic                  cmrg_coord_out_0_ready,
    output logic [DATA_WIDTH-1:0] cmrg_coord_out_1,
    output logic                  cmrg_coord_out_1_valid,
    input  logic                  cmrg_coord_out_1_ready
);
    import coord_dropper_pkg::*;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] held_q, held_d;
    logic                  has_q, has_d;
    logic                  rdy0, rdy1, acc0, acc1, push0, push1;
    logic [DATA_WIDTH-1:0] pdata1;
    logic                  full0, full1, v0, v1, en;
    logic                  done0, ctl0, done1, ctl1;
    logic                  unused_ok;

    assign unused_ok = ^{cmrg_enable, cmrg_stop_lvl};
    assign en    = clk_en && tile_en;
    assign done0 = is_done(cmrg_coord_in_0);
    assign ctl0  = cmrg_coord_in_0[16];
    assign done1 = is_done(cmrg_coord_in_1);
    assign ctl1  = cmrg_coord_in_1[16];

    // Readiness is decided from the presented word alone so acceptance never loops back.
    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        if (!cmrg_mode) begin
            rdy0 = !full0;
            rdy1 = !full1;
        end else begin
            case (state_q)
                ST_START:           rdy1 = (ctl1 && !done1) ? !full1 : 1'b1;
                ST_INNER:           rdy0 = ctl0 ? !full0 : (!full0 && (has_q || !full1));
                ST_DONE_WAIT_INNER: rdy0 = done0 ? (!full0 && !full1) : !full0;
                ST_DONE_WAIT_OUTER: rdy1 = ctl1 ? !full1 : 1'b1;
                default:            rdy1 = 1'b0;
            endcase
        end
    end

    assign cmrg_coord_in_0_ready = rdy0 && tile_en && !rst && !flush;
    assign cmrg_coord_in_1_ready = rdy1 && tile_en && !rst && !flush;
    assign acc0 = cmrg_coord_in_0_valid && cmrg_coord_in_0_ready && clk_en;
    assign acc1 = cmrg_coord_in_1_valid && cmrg_coord_in_1_ready && clk_en;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        has_d   = has_q;
        push0   = 1'b0;
        push1   = 1'b0;
        pdata1  = cmrg_coord_in_1;
        if (!cmrg_mode) begin
            push0 = acc0;
            push1 = acc1;
        end else begin
            case (state_q)
                ST_START: if (acc1) begin
                    if (done1) begin
                        state_d = ST_DONE_WAIT_INNER;
                    end else if (ctl1) begin
                        push1 = 1'b1;
                    end else begin
                        held_d  = cmrg_coord_in_1;
                        has_d   = 1'b0;
                        state_d = ST_INNER;
                    end
                end
                ST_INNER: if (acc0) begin
                    push0 = 1'b1;
                    if (done0) begin
                        state_d = ST_DONE_WAIT_OUTER;
                    end else if (ctl0) begin
                        state_d = ST_START;
                    end else begin
                        push1  = !has_q;
                        pdata1 = held_q;
                        has_d  = 1'b1;
                    end
                end
                ST_DONE_WAIT_INNER: if (acc0) begin
                    push0 = 1'b1;
                    if (done0) begin
                        push1   = 1'b1;
                        pdata1  = DONE_TOKEN;
                        state_d = ST_START;
                    end
                end
                ST_DONE_WAIT_OUTER: if (acc1) begin
                    push1 = ctl1;
                    if (done1) state_d = ST_START;
                end
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_START;
            held_q  <= '0;
            has_q   <= 1'b0;
        end else if (flush) begin
            state_q <= ST_START;
            held_q  <= '0;
            has_q   <= 1'b0;
        end else if (en) begin
            state_q <= state_d;
            held_q  <= held_d;
            has_q   <= has_d;
        end
    end

    stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(flush),
        .push_i(push0), .push_data_i(cmrg_coord_in_0), .full_o(full0),
        .out_valid_o(v0), .out_data_o(cmrg_coord_out_0), .out_ready_i(cmrg_coord_out_0_ready)
    );

    stream_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(flush),
        .push_i(push1), .push_data_i(pdata1), .full_o(full1),
        .out_valid_o(v1), .out_data_o(cmrg_coord_out_1), .out_ready_i(cmrg_coord_out_1_ready)
    );

    assign cmrg_coord_out_0_valid = v0 && tile_en;
    assign cmrg_coord_out_1_valid = v1 && tile_en;

endmodule

// File: tb/tb_coord_dropper.sv
// Scoreboard bench for coord_dropper: a fiber-level reference model fills the
// expected queues, output monitors pop and compare on every handshake.
module tb_coord_dropper;
    import coord_dropper_pkg::*;

    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] DN = 17'h10100;

    logic        clk = 1'b0;
    logic        rst, clk_en, flush, tile_en, cmrg_enable, cmrg_mode;
    logic [15:0] cmrg_stop_lvl;
    logic [16:0] cmrg_coord_in_0, cmrg_coord_in_1, cmrg_coord_out_0, cmrg_coord_out_1;
    logic        cmrg_coord_in_0_valid, cmrg_coord_in_0_ready;
    logic        cmrg_coord_in_1_valid, cmrg_coord_in_1_ready;
    logic        cmrg_coord_out_0_valid, cmrg_coord_out_0_ready;
    logic        cmrg_coord_out_1_valid, cmrg_coord_out_1_ready;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    logic [16:0] stim0[$], stim1[$], exp0[$], exp1[$];

    always #5 clk = ~clk;

    coord_dropper #(.DATA_WIDTH(17), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
        .cmrg_enable(cmrg_enable), .cmrg_mode(cmrg_mode), .cmrg_stop_lvl(cmrg_stop_lvl),
        .cmrg_coord_in_0(cmrg_coord_in_0), .cmrg_coord_in_0_valid(cmrg_coord_in_0_valid),
        .cmrg_coord_in_0_ready(cmrg_coord_in_0_ready),
        .cmrg_coord_in_1(cmrg_coord_in_1), .cmrg_coord_in_1_valid(cmrg_coord_in_1_valid),
        .cmrg_coord_in_1_ready(cmrg_coord_in_1_ready),
        .cmrg_coord_out_0(cmrg_coord_out_0), .cmrg_coord_out_0_valid(cmrg_coord_out_0_valid),
        .cmrg_coord_out_0_ready(cmrg_coord_out_0_ready),
        .cmrg_coord_out_1(cmrg_coord_out_1), .cmrg_coord_out_1_valid(cmrg_coord_out_1_valid),
        .cmrg_coord_out_1_ready(cmrg_coord_out_1_ready)
    );

    task automatic chk(input string name, input logic [16:0] got, input logic [16:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Reference: each outer coordinate owns the next inner fiber (words up to a
    // control token); it survives only if that fiber contains a coordinate.
    task automatic model(input bit mode);
        int ip = 0;
        foreach (stim0[i]) exp0.push_back(stim0[i]);
        if (!mode) begin
            foreach (stim1[i]) exp1.push_back(stim1[i]);
            return;
        end
        foreach (stim1[i]) begin
            if (!stim1[i][16]) begin
                bit nonempty = 1'b0;
                while (ip < stim0.size()) begin
                    logic [16:0] v = stim0[ip];
                    ip++;
                    if (v[16]) break;
                    nonempty = 1'b1;
                end
                if (nonempty) exp1.push_back(stim1[i]);
            end else begin
                exp1.push_back(stim1[i]);
                if (stim1[i] == DN) break;
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (cmrg_coord_out_0_valid && cmrg_coord_out_0_ready && clk_en) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL out0_extra: got %h, expected no word", cmrg_coord_out_0);
            end else chk("out0", cmrg_coord_out_0, exp0.pop_front());
        end
        if (cmrg_coord_out_1_valid && cmrg_coord_out_1_ready && clk_en) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL out1_extra: got %h, expected no word", cmrg_coord_out_1);
            end else chk("out1", cmrg_coord_out_1, exp1.pop_front());
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) begin
            cmrg_coord_out_0_ready = ($urandom_range(0, 2) != 0);
            cmrg_coord_out_1_ready = ($urandom_range(0, 2) != 0);
        end else begin
            cmrg_coord_out_0_ready = (rdy_mode == 0);
            cmrg_coord_out_1_ready = (rdy_mode == 0);
        end
    end

    task automatic send0(input logic [16:0] w, input int gmax);
        int n = 0;
        bit acc = 1'b0;
        repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
        cmrg_coord_in_0 = w;
        cmrg_coord_in_0_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = cmrg_coord_in_0_ready && clk_en;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                checks++; errors++;
                $display("FAIL in0_timeout: got no accept for %h, expected accept", w);
                break;
            end
        end
        cmrg_coord_in_0_valid = 1'b0;
    endtask

    task automatic send1(input logic [16:0] w, input int gmax);
        int n = 0;
        bit acc = 1'b0;
        repeat ($urandom_range(0, gmax)) begin @(posedge clk); #1; end
        cmrg_coord_in_1 = w;
        cmrg_coord_in_1_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = cmrg_coord_in_1_ready && clk_en;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 2000) begin
                checks++; errors++;
                $display("FAIL in1_timeout: got no accept for %h, expected accept", w);
                break;
            end
        end
        cmrg_coord_in_1_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in0_ready", {16'b0, cmrg_coord_in_0_ready}, 17'd0);
        chk("rst_in1_ready", {16'b0, cmrg_coord_in_1_ready}, 17'd0);
        chk("rst_out0_valid", {16'b0, cmrg_coord_out_0_valid}, 17'd0);
        chk("rst_out1_valid", {16'b0, cmrg_coord_out_1_valid}, 17'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", {15'b0, cmrg_coord_out_0_valid, cmrg_coord_out_1_valid}, 17'd0);
    endtask

    task automatic run_case(input string name, input bit mode, input int gmax);
        int n = 0;
        cmrg_mode = mode;
        model(mode);
        fork
            begin foreach (stim0[i]) send0(stim0[i], gmax); end
            begin foreach (stim1[j]) send1(stim1[j], gmax); end
        join
        while ((exp0.size() != 0 || exp1.size() != 0) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d/%0d words outstanding, expected 0/0",
                     name, exp0.size(), exp1.size());
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic gen_random(input int nouter);
        logic [16:0] c, ic;
        stim0 = {};
        stim1 = {};
        for (int f = 0; f < nouter; f++) begin
            int nc = $urandom_range(1, 6);
            c = 17'($urandom_range(0, 20));
            for (int k = 0; k < nc; k++) begin
                int ni = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
                stim1.push_back(c);
                c = c + 17'($urandom_range(1, 3));
                ic = 17'($urandom_range(0, 9));
                for (int m = 0; m < ni; m++) begin
                    stim0.push_back(ic);
                    ic = ic + 17'($urandom_range(1, 4));
                end
                stim0.push_back((k == nc - 1) ? S1 : S0);
            end
            stim1.push_back(S0);
        end
        stim0.push_back(DN);
        stim1.push_back(DN);
    endtask

    task automatic load_basic();
        stim1 = '{17'd0, 17'd1, 17'd2, S0, DN};
        stim0 = '{17'd5, S0, S0, 17'd7, 17'd8, S1, DN};
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
        cmrg_enable = 1'b0; cmrg_mode = 1'b1; cmrg_stop_lvl = '0;
        cmrg_coord_in_0 = '0; cmrg_coord_in_0_valid = 1'b0;
        cmrg_coord_in_1 = '0; cmrg_coord_in_1_valid = 1'b0;
        cmrg_coord_out_0_ready = 1'b1; cmrg_coord_out_1_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        load_basic();
        run_case("basic", 1'b1, 0);
        do_reset();

        stim1 = '{17'd3, S0, DN};
        stim0 = '{17'd9, S0, DN};
        run_case("no_empty", 1'b1, 0);
        do_reset();

        stim1 = '{17'd4, 17'd6, S0, DN};
        stim0 = '{S0, S0, DN};
        run_case("all_empty", 1'b1, 0);
        do_reset();

        load_basic();
        run_case("passthru", 1'b0, 0);
        do_reset();

        rdy_mode = 1;
        gen_random(45);
        run_case("random", 1'b1, 3);
        rdy_mode = 2;
        do_reset();

        // Partial fiber held in the FIFOs, then discarded by flush.
        cmrg_mode = 1'b1;
        send1(17'd0, 0);
        send0(17'd5, 0);
        send0(S0, 0);
        send1(17'd1, 0);
        chk("pre_flush_valid", {15'b0, cmrg_coord_out_0_valid, cmrg_coord_out_1_valid}, 17'd3);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_out_valid", {15'b0, cmrg_coord_out_0_valid, cmrg_coord_out_1_valid}, 17'd0);
        rdy_mode = 0;
        @(posedge clk);
        #1;
        load_basic();
        run_case("after_flush", 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
